// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_ctrl_pkg : shared encodings for branch resolution and BHT   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package branch_ctrl_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  localparam logic [1:0] c_BHT_SNT = 2'b00;
  localparam logic [1:0] c_BHT_WNT = 2'b01;
  localparam logic [1:0] c_BHT_WT  = 2'b10;
  localparam logic [1:0] c_BHT_ST  = 2'b11;

  localparam logic [2:0] c_FNC_BEQ  = 3'b000;
  localparam logic [2:0] c_FNC_BNE  = 3'b001;
  localparam logic [2:0] c_FNC_BLT  = 3'b100;
  localparam logic [2:0] c_FNC_BGE  = 3'b101;
  localparam logic [2:0] c_FNC_BLTU = 3'b110;
  localparam logic [2:0] c_FNC_BGEU = 3'b111;

  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != c_BHT_ST) r = ctr + 2'd1;
    end else begin
      if (ctr != c_BHT_SNT) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage : branch_ctrl_pkg
`default_nettype wire

// File: rtl/branch_ctrl_bht.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_bht : 2-bit saturating counter table, async read, sync upd  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module branch_bht
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BHT_BITS-1:0] i_rd_idx,
  output logic [1:0]          o_rd_ctr,
  input  logic                i_upd_en,
  input  logic [BHT_BITS-1:0] i_upd_idx,
  input  logic                i_upd_taken
);

  localparam int c_ENTRIES = 1 << BHT_BITS;

  logic [1:0] r_ctr [c_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) r_ctr[i] <= c_BHT_WNT;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= bht_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

  // No write-through: a same-cycle update is visible only from the next cycle.
  assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule : branch_bht
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_ctrl : EX-stage branch resolve, redirect/flush, BHT, perf   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_BITS     = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_if_pc,
  output logic             o_if_pred_taken,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic [2:0]       i_ex_funct3,
  input  logic [31:0]      i_ex_pc,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic             i_stall,
  output logic [2:0]       o_branch_sel,
  output logic             o_branch_cmp_en,
  input  logic             i_branch_taken,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int c_FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [c_FC_W-1:0]   r_flush_cnt;
  logic [c_FC_W-1:0]   w_flush_cnt_nxt;
  logic                w_resolve;
  logic                w_mispred;
  logic [1:0]          w_rd_ctr;
  logic                r_redirect_valid;
  logic [31:0]         r_redirect_pc;
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;
  logic                w_unused_bits;

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    o_branch_cmp_en = 1'b0;
    o_flush         = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_branch_cmp_en = i_ex_valid & i_ex_is_branch;
        if (w_resolve && w_mispred) begin
          w_state_nxt     = S_FLUSH;
          w_flush_cnt_nxt = c_FC_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        // Wrong-path instructions are ignored; stall does not hold the count.
        o_flush = 1'b1;
        if (r_flush_cnt == '0) w_state_nxt = S_IDLE;
        else                   w_flush_cnt_nxt = r_flush_cnt - c_FC_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  assign w_resolve    = o_branch_cmp_en & ~i_stall;
  assign w_mispred    = i_branch_taken ^ i_ex_pred_taken;
  assign o_branch_sel = i_ex_funct3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_resolve & w_mispred;
      if (w_resolve && w_mispred)
        r_redirect_pc <= i_branch_taken ? i_ex_target : i_ex_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_resolve) begin
      r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mispred) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  branch_bht #(
    .BHT_BITS (BHT_BITS)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (i_if_pc[BHT_BITS+1:2]),
    .o_rd_ctr    (w_rd_ctr),
    .i_upd_en    (w_resolve),
    .i_upd_idx   (i_ex_pc[BHT_BITS+1:2]),
    .i_upd_taken (i_branch_taken)
  );

  assign o_if_pred_taken  = w_rd_ctr[1];
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispred_cnt    = r_mispred_cnt;

  assign w_unused_bits = ^{i_if_pc[31:BHT_BITS+2], i_if_pc[1:0], w_rd_ctr[0]};

endmodule : branch_ctrl
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_branch_ctrl : vector table + scoreboard bench for branch_ctrl   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_if_pc = '0;
  logic        o_if_pred_taken;
  logic        i_ex_valid = 1'b0;
  logic        i_ex_is_branch = 1'b0;
  logic [2:0]  i_ex_funct3 = '0;
  logic [31:0] i_ex_pc = '0;
  logic [31:0] i_ex_target = '0;
  logic        i_ex_pred_taken = 1'b0;
  logic        i_stall = 1'b0;
  logic [2:0]  o_branch_sel;
  logic        o_branch_cmp_en;
  logic        i_branch_taken = 1'b0;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_flush;
  logic        i_clr_cnt = 1'b0;
  logic [31:0] o_branch_cnt;
  logic [31:0] o_mispred_cnt;

  branch_ctrl #(.BHT_BITS(6), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_if_pc(i_if_pc), .o_if_pred_taken(o_if_pred_taken),
    .i_ex_valid(i_ex_valid), .i_ex_is_branch(i_ex_is_branch), .i_ex_funct3(i_ex_funct3),
    .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target), .i_ex_pred_taken(i_ex_pred_taken),
    .i_stall(i_stall), .o_branch_sel(o_branch_sel), .o_branch_cmp_en(o_branch_cmp_en),
    .i_branch_taken(i_branch_taken), .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc(o_redirect_pc), .o_flush(o_flush), .i_clr_cnt(i_clr_cnt),
    .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [2:0]  f3;
    logic        pred;
    logic        taken;
  } vec_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  vec_t        vec [7];
  exp_t        exp_q [$];
  exp_t        e;
  logic [1:0]  m_bht [64];
  logic [31:0] m_bc, m_mc, m_rpc;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_bc = '0; m_mc = '0; m_rpc = '0;
  endtask

  // Reference behaviour of one committed branch.
  task automatic model_resolve(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic pred, input logic taken);
    logic [5:0] idx;
    idx = pc[7:2];
    if (taken && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
    if (!taken && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
    m_bc = m_bc + 32'd1;
    if (taken != pred) begin
      m_mc  = m_mc + 32'd1;
      m_rpc = taken ? tgt : pc + 32'd4;
    end
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                        input logic pred, input logic taken);
    i_ex_valid = 1'b1; i_ex_is_branch = 1'b1; i_ex_pc = pc; i_ex_target = tgt;
    i_ex_funct3 = f3; i_ex_pred_taken = pred; i_branch_taken = taken; i_if_pc = pc;
  endtask

  task automatic clr_br();
    i_ex_valid = 1'b0; i_ex_is_branch = 1'b0; i_branch_taken = 1'b0;
  endtask

  initial begin
    logic       mis;
    logic [1:0] ctr_tmp;
    logic [31:0] bc0;
    logic       exp_before [3];

    vec[0] = '{32'h0000_0100, 32'h0000_0180, 3'b000, 1'b0, 1'b1};
    vec[1] = '{32'h0000_01FC, 32'h0000_0300, 3'b001, 1'b1, 1'b0};
    vec[2] = '{32'h0000_0200, 32'h0000_0280, 3'b100, 1'b0, 1'b0};
    vec[3] = '{32'h0000_0204, 32'h0000_0100, 3'b101, 1'b1, 1'b1};
    vec[4] = '{32'h0000_0208, 32'h0000_0400, 3'b010, 1'b1, 1'b0};
    vec[5] = '{32'hFFFF_FFFC, 32'h0000_0040, 3'b111, 1'b1, 1'b0};
    vec[6] = '{32'h0000_0104, 32'h0000_0010, 3'b110, 1'b1, 1'b1};
    model_reset();

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_flush", 32'(o_flush), 32'd0);
    check("rst_redirect_valid", 32'(o_redirect_valid), 32'd0);
    check("rst_redirect_pc", o_redirect_pc, 32'd0);
    check("rst_branch_cnt", o_branch_cnt, 32'd0);
    check("rst_mispred_cnt", o_mispred_cnt, 32'd0);
    for (int k = 0; k < 4; k++) begin
      i_if_pc = 32'(k * 32'h44 + 32'h100);
      #1 check("rst_pred", 32'(o_if_pred_taken), 32'd0);
    end

    // Table-driven vectors with scoreboard of post-edge expectations.
    for (int k = 0; k < 7; k++) begin
      set_br(vec[k].pc, vec[k].tgt, vec[k].f3, vec[k].pred, vec[k].taken);
      #1;
      check("vec_cmp_en", 32'(o_branch_cmp_en), 32'd1);
      check("vec_branch_sel", 32'(o_branch_sel), 32'(vec[k].f3));
      ctr_tmp = m_bht[vec[k].pc[7:2]];
      check("vec_if_pred", 32'(o_if_pred_taken), 32'(ctr_tmp[1]));
      mis = vec[k].taken ^ vec[k].pred;
      model_resolve(vec[k].pc, vec[k].tgt, vec[k].pred, vec[k].taken);
      exp_q.push_back('{mis, m_rpc, m_bc, m_mc});
      step();
      clr_br();
      e = exp_q.pop_front();
      check("vec_redirect_valid", 32'(o_redirect_valid), 32'(e.rv));
      check("vec_redirect_pc", o_redirect_pc, e.rpc);
      check("vec_branch_cnt", o_branch_cnt, e.bc);
      check("vec_mispred_cnt", o_mispred_cnt, e.mc);
      check("vec_flush_t1", 32'(o_flush), 32'(mis));
      if (mis) begin
        step();
        check("vec_redirect_once", 32'(o_redirect_valid), 32'd0);
        check("vec_flush_t2", 32'(o_flush), 32'd1);
        step();
        check("vec_flush_end", 32'(o_flush), 32'd0);
      end
    end
    i_if_pc = 32'h0000_01FC;
    #1 check("bht_1fc_pred", 32'(o_if_pred_taken), 32'd0);

    // Branch sitting in EX during flush is wrong-path; resolves on first IDLE cycle.
    set_br(32'h0000_0400, 32'h0000_0500, 3'b000, 1'b0, 1'b1);
    model_resolve(32'h0000_0400, 32'h0000_0500, 1'b0, 1'b1);
    step();
    set_br(32'h0000_0404, 32'h0000_0600, 3'b001, 1'b0, 1'b1);
    #1;
    check("wp_cmp_en", 32'(o_branch_cmp_en), 32'd0);
    check("wp_redirect_pc", o_redirect_pc, 32'h0000_0500);
    step();
    check("wp_no_redirect", 32'(o_redirect_valid), 32'd0);
    check("wp_branch_cnt", o_branch_cnt, m_bc);
    check("wp_flush_t2", 32'(o_flush), 32'd1);
    step();
    check("wp_flush_off", 32'(o_flush), 32'd0);
    check("wp_cmp_en_idle", 32'(o_branch_cmp_en), 32'd1);
    model_resolve(32'h0000_0404, 32'h0000_0600, 1'b0, 1'b1);
    step();
    clr_br();
    check("wp_resolve_rv", 32'(o_redirect_valid), 32'd1);
    check("wp_resolve_pc", o_redirect_pc, 32'h0000_0600);
    check("wp_resolve_cnt", o_branch_cnt, m_bc);
    repeat (2) step();

    // Same branch taken 3x with stall toggling: 01->10->11->11, then NT -> 10.
    exp_before[0] = 1'b0; exp_before[1] = 1'b1; exp_before[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_br(32'h0000_03F0, 32'h0000_0800, 3'b000, 1'b1, 1'b1);
      i_stall = 1'b1;
      bc0 = m_bc;
      #1 check("sat_pred_before", 32'(o_if_pred_taken), 32'(exp_before[j]));
      step();
      check("sat_stall_cnt", o_branch_cnt, bc0);
      check("sat_stall_pred", 32'(o_if_pred_taken), 32'(exp_before[j]));
      i_stall = 1'b0;
      #1 check("sat_same_cycle_pred", 32'(o_if_pred_taken), 32'(exp_before[j]));
      model_resolve(32'h0000_03F0, 32'h0000_0800, 1'b1, 1'b1);
      step();
      check("sat_cnt", o_branch_cnt, bc0 + 32'd1);
      check("sat_pred_after", 32'(o_if_pred_taken), 32'd1);
    end
    set_br(32'h0000_03F0, 32'h0000_0800, 3'b000, 1'b0, 1'b0);
    model_resolve(32'h0000_03F0, 32'h0000_0800, 1'b0, 1'b0);
    step();
    check("sat_nt_pred", 32'(o_if_pred_taken), 32'd1);
    check("sat_nt_no_flush", 32'(o_flush), 32'd0);

    // Clear beats a concurrent increment.
    set_br(32'h0000_0500, 32'h0000_0900, 3'b001, 1'b0, 1'b1);
    i_clr_cnt = 1'b1;
    model_resolve(32'h0000_0500, 32'h0000_0900, 1'b0, 1'b1);
    m_bc = '0; m_mc = '0;
    step();
    clr_br();
    i_clr_cnt = 1'b0;
    check("clr_branch_cnt", o_branch_cnt, m_bc);
    check("clr_mispred_cnt", o_mispred_cnt, m_mc);
    repeat (2) step();

    // Asynchronous reset during the flush window.
    set_br(32'h0000_0600, 32'h0000_0A00, 3'b000, 1'b0, 1'b1);
    step();
    check("ar_flush_pre", 32'(o_flush), 32'd1);
    check("ar_rv_pre", 32'(o_redirect_valid), 32'd1);
    rst_n = 1'b0;
    clr_br();
    model_reset();
    #1;
    check("ar_flush", 32'(o_flush), 32'd0);
    check("ar_redirect_valid", 32'(o_redirect_valid), 32'd0);
    check("ar_redirect_pc", o_redirect_pc, m_rpc);
    check("ar_branch_cnt", o_branch_cnt, m_bc);
    step();
    rst_n = 1'b1;
    i_if_pc = 32'h0000_03F0;
    step();
    check("ar_bht_reset", 32'(o_if_pred_taken), 32'd0);
    check("ar_flush_post", 32'(o_flush), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_branch_ctrl
`default_nettype wire
